// File: rtl/bist_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bist_pkg
// Description : Shared definitions for the BIST signature checker: FSM state
//               encoding, default MISR polynomial/seed, width limits and the
//               single-step MISR next-state helper.
// Revision    : 1.0 - initial release
// ============================================================================
package bist_pkg;

  // Width limits for the signature register and the shift counter
  localparam int BIST_MIN_MISR_WIDTH = 2;
  localparam int BIST_MAX_MISR_WIDTH = 64;
  localparam int BIST_MAX_CNT_WIDTH  = 32;

  // Default MISR feedback polynomial x^16+x^12+x^3+x+1 and seed
  localparam logic [15:0] BIST_DEFAULT_POLY = 16'h100B;
  localparam logic [15:0] BIST_DEFAULT_SEED = 16'h0000;

  // Checker FSM state encoding (2 bits)
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COMPACT = 2'd1;
  localparam logic [1:0] ST_COMPARE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  // One MISR step on zero-extended operands. The caller passes the real MSB
  // of its register as fb and truncates the result back to its own width,
  // so the bits shifted above the register width are simply discarded.
  function automatic logic [BIST_MAX_MISR_WIDTH-1:0] misr_step(
    input logic [BIST_MAX_MISR_WIDTH-1:0] sig,
    input logic                           fb,
    input logic [BIST_MAX_MISR_WIDTH-1:0] poly,
    input logic [BIST_MAX_MISR_WIDTH-1:0] data
  );
    return {sig[BIST_MAX_MISR_WIDTH-2:0], 1'b0} ^ (fb ? poly : '0) ^ data;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bist_misr.sv
`default_nettype none
// ============================================================================
// Module      : bist_misr
// Description : Multiple-input signature register. Loads the seed on reset or
//               load, otherwise shifts/compacts data_in when enabled.
// Revision    : 1.0 - initial release
// ============================================================================
module bist_misr
  import bist_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(BIST_DEFAULT_POLY)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             enable,
  input  logic [WIDTH-1:0] seed,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] sig
);

  logic [WIDTH-1:0] r_sig;
  logic [WIDTH-1:0] w_next;

  assign w_next = WIDTH'(misr_step(BIST_MAX_MISR_WIDTH'(r_sig),
                                   r_sig[WIDTH-1],
                                   BIST_MAX_MISR_WIDTH'(POLY),
                                   BIST_MAX_MISR_WIDTH'(data_in)));

  // Signature register: reset and load take priority over compaction
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sig <= seed;
    end else if (load) begin
      r_sig <= seed;
    end else if (enable) begin
      r_sig <= w_next;
    end
  end

  assign sig = r_sig;

endmodule
`default_nettype wire

// File: rtl/bist_signature_checker.sv
`default_nettype none
// ============================================================================
// Module      : bist_signature_checker
// Description : Compacts scan-chain outputs into a MISR during BIST shift
//               cycles, counts compacted cycles and compares the final
//               signature against a golden value when the controller finishes.
//               Optional feature macro: BIST_X_MASK_EN adds an x_mask input
//               that forces masked scan_out bits to 0 before compaction.
// Revision    : 1.0 - initial release
// ============================================================================
module bist_signature_checker
  import bist_pkg::*;
#(
  parameter int                    MISR_WIDTH = 16,
  parameter int                    NUM_CHAINS = 1,
  parameter logic [MISR_WIDTH-1:0] MISR_POLY  = MISR_WIDTH'(BIST_DEFAULT_POLY),
  parameter logic [MISR_WIDTH-1:0] MISR_SEED  = MISR_WIDTH'(BIST_DEFAULT_SEED),
  parameter logic [MISR_WIDTH-1:0] GOLDEN_SIG = '0,
  parameter int                    CNT_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  init,
  input  logic                  mode,
  input  logic                  running,
  input  logic                  finish,
  input  logic [NUM_CHAINS-1:0] scan_out,
`ifdef BIST_X_MASK_EN
  input  logic [NUM_CHAINS-1:0] x_mask,
`endif
  output logic [MISR_WIDTH-1:0] signature,
  output logic [CNT_WIDTH-1:0]  shift_count,
  output logic                  result_valid,
  output logic                  pass,
  output logic                  fail
);

  logic [1:0]            r_state;
  logic [CNT_WIDTH-1:0]  r_count;
  logic                  r_valid;
  logic                  r_pass;
  logic                  r_fail;

  logic [NUM_CHAINS-1:0] w_scan;
  logic [MISR_WIDTH-1:0] w_data;
  logic [MISR_WIDTH-1:0] w_sig;
  logic [MISR_WIDTH-1:0] w_next_sig;
  logic                  w_compact;
  logic                  w_match;

`ifdef BIST_X_MASK_EN
  // Unknown scan bits are suppressed so they cannot corrupt the signature
  assign w_scan = scan_out & ~x_mask;
`else
  assign w_scan = scan_out;
`endif

  assign w_data = MISR_WIDTH'(w_scan);

  // init restarts the session, so it blocks a compaction in the same cycle
  assign w_compact = (r_state == ST_COMPACT) && running && mode && !init;

  // Signature the MISR will hold after this edge; a compaction on the finish
  // cycle must be visible to the compare
  assign w_next_sig = w_compact
                    ? MISR_WIDTH'(misr_step(BIST_MAX_MISR_WIDTH'(w_sig),
                                            w_sig[MISR_WIDTH-1],
                                            BIST_MAX_MISR_WIDTH'(MISR_POLY),
                                            BIST_MAX_MISR_WIDTH'(w_data)))
                    : w_sig;

  assign w_match = (w_next_sig == GOLDEN_SIG);

  bist_misr #(
    .WIDTH (MISR_WIDTH),
    .POLY  (MISR_POLY)
  ) u_misr (
    .clock   (clock),
    .reset   (reset),
    .load    (init),
    .enable  (w_compact),
    .seed    (MISR_SEED),
    .data_in (w_data),
    .sig     (w_sig)
  );

  // Session FSM with saturating shift counter and registered compare result
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_valid <= 1'b0;
      r_pass  <= 1'b0;
      r_fail  <= 1'b0;
    end else if (init) begin
      r_state <= ST_COMPACT;
      r_count <= '0;
      r_valid <= 1'b0;
      r_pass  <= 1'b0;
      r_fail  <= 1'b0;
    end else begin
      case (r_state)
        ST_COMPACT: begin
          if (w_compact && (r_count != {CNT_WIDTH{1'b1}})) begin
            r_count <= r_count + CNT_WIDTH'(1);
          end
          if (finish) begin
            r_state <= ST_COMPARE;
            r_valid <= 1'b1;
            r_pass  <= w_match;
            r_fail  <= !w_match;
          end
        end
        ST_COMPARE: begin
          r_state <= ST_DONE;
        end
        ST_IDLE, ST_DONE: begin
          r_state <= r_state;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign signature    = w_sig;
  assign shift_count  = r_count;
  assign result_valid = r_valid;
  assign pass         = r_pass;
  assign fail         = r_fail;

endmodule
`default_nettype wire

// File: tb/tb_bist_signature_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_bist_signature_checker
// Description : Self-checking bench for bist_signature_checker. A session
//               model (polynomial multiply-by-x mod p plus a phase counter)
//               predicts every output after every clock.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bist_signature_checker;

  localparam int          c_w      = 16;
  localparam int          c_nc     = 1;
  localparam int          c_cw     = 4;
  localparam int          c_cmax   = 15;
  localparam logic [15:0] c_poly   = 16'h100B;
  localparam logic [15:0] c_seed   = 16'h0000;
  localparam logic [15:0] c_golden = 16'h0000;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            init = 1'b0;
  logic            mode = 1'b0;
  logic            running = 1'b0;
  logic            finish = 1'b0;
  logic [c_nc-1:0] scan_out = '0;
  logic [c_nc-1:0] x_mask = '0;
  logic [c_w-1:0]  signature;
  logic [c_cw-1:0] shift_count;
  logic            result_valid;
  logic            pass;
  logic            fail;

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0 idle, 1 compacting, 2 comparing, 3 done
  int          m_phase = 0;
  logic [15:0] m_sig = c_seed;
  int          m_cnt = 0;
  bit          m_valid = 0;
  bit          m_pass = 0;
  bit          m_fail = 0;

  bist_signature_checker #(
    .MISR_WIDTH (c_w),
    .NUM_CHAINS (c_nc),
    .MISR_POLY  (c_poly),
    .MISR_SEED  (c_seed),
    .GOLDEN_SIG (c_golden),
    .CNT_WIDTH  (c_cw)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .init         (init),
    .mode         (mode),
    .running      (running),
    .finish       (finish),
    .scan_out     (scan_out),
`ifdef BIST_X_MASK_EN
    .x_mask       (x_mask),
`endif
    .signature    (signature),
    .shift_count  (shift_count),
    .result_valid (result_valid),
    .pass         (pass),
    .fail         (fail)
  );

  always #5 clock = ~clock;

  // Signature times x modulo the polynomial, plus the incoming data bit
  function automatic logic [15:0] model_step(input logic [15:0] s, input bit d);
    int v;
    v = int'(s) * 2;
    if (v >= 65536) v = (v - 65536) ^ int'(c_poly);
    return 16'(v) ^ 16'(d);
  endfunction

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "/signature"},    32'(signature),    32'(m_sig));
    check({tag, "/shift_count"},  32'(shift_count),  32'(m_cnt));
    check({tag, "/result_valid"}, 32'(result_valid), 32'(m_valid));
    check({tag, "/pass"},         32'(pass),         32'(m_pass));
    check({tag, "/fail"},         32'(fail),         32'(m_fail));
  endtask

  // Drive one clock of inputs, advance the model, then compare after the edge
  task automatic cyc(input string tag, input bit rst_i, input bit init_i,
                     input bit mode_i, input bit run_i, input bit fin_i,
                     input bit scan_i, input bit mask_i);
    bit d;
    reset    = rst_i;
    init     = init_i;
    mode     = mode_i;
    running  = run_i;
    finish   = fin_i;
    scan_out = scan_i;
    x_mask   = mask_i;
    @(posedge clock);
    d = scan_i;
`ifdef BIST_X_MASK_EN
    if (mask_i) d = 1'b0;
`endif
    if (rst_i) begin
      m_phase = 0; m_sig = c_seed; m_cnt = 0;
      m_valid = 0; m_pass = 0; m_fail = 0;
    end else if (init_i) begin
      m_phase = 1; m_sig = c_seed; m_cnt = 0;
      m_valid = 0; m_pass = 0; m_fail = 0;
    end else if (m_phase == 1) begin
      if (run_i && mode_i) begin
        m_sig = model_step(m_sig, d);
        if (m_cnt < c_cmax) m_cnt++;
      end
      if (fin_i) begin
        m_phase = 2;
        m_valid = 1;
        m_pass  = (m_sig == c_golden);
        m_fail  = !m_pass;
      end
    end else if (m_phase == 2) begin
      m_phase = 3;
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    // Reset, then idle
    cyc("reset", 1, 0, 0, 0, 0, 0, 0);
    cyc("reset", 1, 1, 1, 1, 1, 1, 0);
    for (int i = 0; i < 10; i++) cyc("idle", 0, 0, 0, 0, 0, 0, 0);
    check("idle/sig_is_0000", 32'(signature), 32'h0000);

    // 13 zero shifts, finish: pass one cycle after finish
    cyc("zero_init", 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 13; i++) cyc("zero_shift", 0, 0, 1, 1, 0, 0, 0);
    cyc("zero_finish", 0, 0, 0, 1, 1, 0, 0);
    check("zero/count13", 32'(shift_count), 32'd13);
    check("zero/pass", 32'(pass), 32'd1);
    cyc("zero_compare", 0, 0, 0, 0, 0, 0, 0);
    cyc("done_finish_ignored", 0, 0, 1, 1, 1, 1, 0);
    cyc("done_hold", 0, 0, 0, 0, 0, 0, 0);

    // Single one shift then finish: signature 0001, fail
    cyc("one_init", 0, 1, 0, 0, 0, 0, 0);
    cyc("one_shift", 0, 0, 1, 1, 0, 1, 0);
    cyc("one_finish", 0, 0, 0, 1, 1, 0, 0);
    check("one/sig0001", 32'(signature), 32'h0001);
    check("one/fail", 32'(fail), 32'd1);
    cyc("one_done", 0, 0, 0, 0, 0, 0, 0);

    // Shift on the same cycle as finish must reach the compare
    cyc("samecyc_init", 0, 1, 0, 0, 0, 0, 0);
    cyc("samecyc_shift_finish", 0, 0, 1, 1, 1, 1, 0);
    check("samecyc/sig0001", 32'(signature), 32'h0001);

    // Random shift/capture/stall interleaving
    cyc("rand_init", 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++)
      cyc("rand", 0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0,
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    cyc("rand_finish", 0, 0, 1, 1, 1, 1'($urandom_range(0, 1)), 0);
    cyc("rand_done", 0, 0, 0, 0, 0, 0, 0);

    // init and finish together: init wins, session stays in compaction
    cyc("initfin", 0, 1, 0, 1, 1, 0, 0);
    check("initfin/valid0", 32'(result_valid), 32'd0);
    cyc("initfin_shift", 0, 0, 1, 1, 0, 1, 0);
    check("initfin/count1", 32'(shift_count), 32'd1);
    cyc("initfin_finish", 0, 0, 0, 0, 1, 0, 0);

    // Reset mid-compaction aborts; later finish and shifts are ignored
    cyc("abort_init", 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      cyc("abort_shift", 0, 0, 1, 1, 0, 1'($urandom_range(0, 1)), 0);
    cyc("abort_reset", 1, 0, 1, 1, 1, 1, 0);
    cyc("abort_finish", 0, 0, 0, 1, 1, 0, 0);
    cyc("abort_finish", 0, 0, 1, 1, 1, 1, 0);
    cyc("abort_idle_shift", 0, 0, 1, 1, 0, 1, 0);
    check("abort/valid0", 32'(result_valid), 32'd0);

    // Counter saturates at all-ones
    cyc("sat_init", 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++)
      cyc("sat_shift", 0, 0, 1, 1, 0, 1'($urandom_range(0, 1)), 0);
    check("sat/count15", 32'(shift_count), 32'd15);
    cyc("sat_finish", 0, 0, 0, 1, 1, 0, 0);
    cyc("sat_done", 0, 0, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
